// File: rtl/fcb_apb_master_pkg.sv
// Shared types and defaults for the FCB APB3 initiator: FSM state encoding,
// default bus widths and the watchdog default.
package fcb_apb_master_pkg;

    localparam int unsigned ADDR_W_DEF      = 32;
    localparam int unsigned DATA_W_DEF      = 32;
    localparam int unsigned TIMEOUT_CYC_DEF = 1024;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
        return addr_lsb == 2'b00;
    endfunction

endpackage

// File: rtl/fcb_apb_master_if.sv
// Request/response handshake plus APB3 bus of the FCB initiator, with a debug
// view of the FSM state. master = initiator side, slave = requester/APB side.
interface fcb_apb_master_if
    import fcb_apb_master_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) ();

    // Both handshakes: a beat transfers on the edge where valid & ready are
    // both high; valid and its payload stay stable until that edge.
    logic              req_valid_i;
    logic              req_ready_o;
    logic              req_write_i;
    logic [ADDR_W-1:0] req_addr_i;
    logic [DATA_W-1:0] req_wdata_i;

    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [DATA_W-1:0] rsp_rdata_o;
    logic              rsp_err_o;
    logic              rsp_timeout_o;

    logic              busy_o;
    state_t            dbg_state_o;

    logic              apbm_psel_o;
    logic              apbm_penable_o;
    logic              apbm_pwrite_o;
    logic [ADDR_W-1:0] apbm_paddr_o;
    logic [DATA_W-1:0] apbm_pwdata_o;
    logic [DATA_W-1:0] apbm_prdata_i;
    logic              apbm_pready_i;
    logic              apbm_pslverr_i;

    modport master (
        input  req_valid_i, req_write_i, req_addr_i, req_wdata_i, rsp_ready_i,
               apbm_prdata_i, apbm_pready_i, apbm_pslverr_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
               busy_o, dbg_state_o, apbm_psel_o, apbm_penable_o, apbm_pwrite_o,
               apbm_paddr_o, apbm_pwdata_o
    );

    modport slave (
        output req_valid_i, req_write_i, req_addr_i, req_wdata_i, rsp_ready_i,
               apbm_prdata_i, apbm_pready_i, apbm_pslverr_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
               busy_o, dbg_state_o, apbm_psel_o, apbm_penable_o, apbm_pwrite_o,
               apbm_paddr_o, apbm_pwdata_o
    );

endinterface

// File: rtl/fcb_apb_master_wdog.sv
// ACCESS-phase watchdog for fcb_apb_master; only present when FCB_APBM_TIMEOUT_EN
// is defined. expired is high on the TIMEOUT_CYC-th enabled cycle after clear.
`ifdef FCB_APBM_TIMEOUT_EN
module fcb_apb_master_wdog #(
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic fcb_clk_i,
    input  logic fcb_rst_ni,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned       CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] TERM  = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge fcb_clk_i or negedge fcb_rst_ni) begin
        if (!fcb_rst_ni) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && !expired) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired = en && (cnt_q == TERM);

endmodule
`endif

// File: rtl/fcb_apb_master.sv
// APB3 initiator for the FCB configuration port: one request in, one APB
// transfer out, one response back. Watchdog abort enabled by FCB_APBM_TIMEOUT_EN.
module fcb_apb_master
    import fcb_apb_master_pkg::*;
#(
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              fcb_clk_i,
    input  logic              fcb_rst_ni,
    fcb_apb_master_if.master  bus
);

    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("fcb_apb_master: TIMEOUT_CYC must be >= 2");
    end

    state_t            state_q, state_d;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic              tout_q;
    logic              accept;
    logic              aligned;
    logic              wdog_expired;

    assign accept  = bus.req_valid_i && (state_q == ST_IDLE);
    assign aligned = is_word_aligned(bus.req_addr_i[1:0]);

`ifdef FCB_APBM_TIMEOUT_EN
    fcb_apb_master_wdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wdog (
        .fcb_clk_i  (fcb_clk_i),
        .fcb_rst_ni (fcb_rst_ni),
        .clr        (state_q == ST_SETUP),
        .en         (state_q == ST_ACCESS),
        .expired    (wdog_expired)
    );
`else
    assign wdog_expired = 1'b0;
`endif

    always_ff @(posedge fcb_clk_i or negedge fcb_rst_ni) begin
        if (!fcb_rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // pready wins over a watchdog expiry in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept) state_d = aligned ? ST_SETUP : ST_RESP;
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: if (bus.apbm_pready_i || wdog_expired) state_d = ST_RESP;
            ST_RESP:   if (bus.rsp_ready_i) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Address/data only move on an aligned accept so paddr/pwdata never
    // change while psel is low.
    always_ff @(posedge fcb_clk_i or negedge fcb_rst_ni) begin
        if (!fcb_rst_ni) begin
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            tout_q  <= 1'b0;
        end else begin
            if (accept && aligned) begin
                wr_q    <= bus.req_write_i;
                addr_q  <= bus.req_addr_i;
                wdata_q <= bus.req_wdata_i;
            end
            if (accept && !aligned) begin
                rdata_q <= '0;
                err_q   <= 1'b1;
                tout_q  <= 1'b0;
            end
            if (state_q == ST_ACCESS) begin
                if (bus.apbm_pready_i) begin
                    rdata_q <= wr_q ? '0 : bus.apbm_prdata_i;
                    err_q   <= bus.apbm_pslverr_i;
                    tout_q  <= 1'b0;
                end else if (wdog_expired) begin
                    rdata_q <= '0;
                    err_q   <= 1'b1;
                    tout_q  <= 1'b1;
                end
            end
        end
    end

    assign bus.req_ready_o    = (state_q == ST_IDLE);
    assign bus.busy_o         = (state_q != ST_IDLE);
    assign bus.rsp_valid_o    = (state_q == ST_RESP);
    assign bus.rsp_rdata_o    = rdata_q;
    assign bus.rsp_err_o      = err_q;
    assign bus.rsp_timeout_o  = tout_q;
    assign bus.dbg_state_o    = state_q;

    assign bus.apbm_psel_o    = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    assign bus.apbm_penable_o = (state_q == ST_ACCESS);
    assign bus.apbm_pwrite_o  = wr_q;
    assign bus.apbm_paddr_o   = addr_q;
    assign bus.apbm_pwdata_o  = wdata_q;

endmodule

// File: tb/tb_fcb_apb_master.sv
// Directed bench for fcb_apb_master: APB timing, response handshake, misalign,
// slave error, reset abort and (with FCB_APBM_TIMEOUT_EN) watchdog abort.
module tb_fcb_apb_master;
    import fcb_apb_master_pkg::*;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned TO_CYC  = 8;
    localparam int unsigned RSP_W   = DATA_W + 2;

    logic fcb_clk_i;
    logic fcb_rst_ni;

    fcb_apb_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_if ();

    fcb_apb_master #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .TIMEOUT_CYC (TO_CYC)
    ) dut (
        .fcb_clk_i  (fcb_clk_i),
        .fcb_rst_ni (fcb_rst_ni),
        .bus        (bus_if)
    );

    // clock / reset
    initial fcb_clk_i = 1'b0;
    always #5 fcb_clk_i = ~fcb_clk_i;

    initial begin
        #200000;
        $display("FAIL global_timeout sim did not finish");
        $fatal(1, "global timeout");
    end

    // scoreboard: {timeout, err, rdata}
    logic [RSP_W-1:0] exp_q[$];
    int checks   = 0;
    int failures = 0;

    task automatic tick();
        @(posedge fcb_clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_rsp(input string tag);
        logic [RSP_W-1:0] exp;
        if (exp_q.size() == 0) begin
            chk({tag, "_queue_empty"}, 64'd1, 64'd0);
        end else begin
            exp = exp_q.pop_front();
            chk(tag, 64'({bus_if.rsp_timeout_o, bus_if.rsp_err_o, bus_if.rsp_rdata_o}), 64'(exp));
        end
    endtask

    // driver: present a request until accepted; returns #1 after the accept edge
    task automatic accept(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        int n = 0;
        while (!bus_if.req_ready_o && n < 32) begin
            tick();
            n++;
        end
        chk("accept_ready", 64'(bus_if.req_ready_o), 64'd1);
        bus_if.req_valid_i = 1'b1;
        bus_if.req_write_i = w;
        bus_if.req_addr_i  = a;
        bus_if.req_wdata_i = d;
        tick();
        bus_if.req_valid_i = 1'b0;
    endtask

    // full transfer: pready asserted after 'waits' ACCESS cycles
    task automatic run_xfer(input string tag, input logic w, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] d, input int waits,
                            input logic [DATA_W-1:0] prd, input logic serr);
        int n = 0;
        accept(w, a, d);
        tick();
        for (int i = 0; i < waits; i++) tick();
        bus_if.apbm_pready_i  = 1'b1;
        bus_if.apbm_prdata_i  = prd;
        bus_if.apbm_pslverr_i = serr;
        while (!bus_if.rsp_valid_o && n < 64) begin
            tick();
            n++;
        end
        bus_if.apbm_pready_i  = 1'b0;
        bus_if.apbm_pslverr_i = 1'b0;
        chk({tag, "_rsp_valid"}, 64'(bus_if.rsp_valid_o), 64'd1);
        check_rsp(tag);
        bus_if.rsp_ready_i = 1'b1;
        tick();
        bus_if.rsp_ready_i = 1'b0;
    endtask

    initial begin
        fcb_rst_ni            = 1'b0;
        bus_if.req_valid_i    = 1'b0;
        bus_if.req_write_i    = 1'b0;
        bus_if.req_addr_i     = '0;
        bus_if.req_wdata_i    = '0;
        bus_if.rsp_ready_i    = 1'b0;
        bus_if.apbm_prdata_i  = '0;
        bus_if.apbm_pready_i  = 1'b0;
        bus_if.apbm_pslverr_i = 1'b0;

        // reset state
        tick();
        tick();
        chk("rst_req_ready", 64'(bus_if.req_ready_o), 64'd1);
        chk("rst_psel",      64'(bus_if.apbm_psel_o), 64'd0);
        chk("rst_penable",   64'(bus_if.apbm_penable_o), 64'd0);
        chk("rst_rsp_valid", 64'(bus_if.rsp_valid_o), 64'd0);
        chk("rst_busy",      64'(bus_if.busy_o), 64'd0);
        chk("rst_paddr",     64'(bus_if.apbm_paddr_o), 64'd0);
        chk("rst_pwdata",    64'(bus_if.apbm_pwdata_o), 64'd0);
        chk("rst_rsp",       64'({bus_if.rsp_timeout_o, bus_if.rsp_err_o, bus_if.rsp_rdata_o}), 64'd0);
        chk("rst_state",     64'(bus_if.dbg_state_o), 64'(ST_IDLE));
        fcb_rst_ni = 1'b1;
        tick();

        // 1: zero-wait write, exact latency
        exp_q.push_back({1'b0, 1'b0, 32'h0});
        accept(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        chk("t1_setup_psel",    64'(bus_if.apbm_psel_o), 64'd1);
        chk("t1_setup_penable", 64'(bus_if.apbm_penable_o), 64'd0);
        chk("t1_setup_paddr",   64'(bus_if.apbm_paddr_o), 64'h10);
        chk("t1_setup_pwrite",  64'(bus_if.apbm_pwrite_o), 64'd1);
        chk("t1_setup_pwdata",  64'(bus_if.apbm_pwdata_o), 64'hDEAD_BEEF);
        chk("t1_setup_ready",   64'(bus_if.req_ready_o), 64'd0);
        chk("t1_setup_busy",    64'(bus_if.busy_o), 64'd1);
        bus_if.apbm_pready_i = 1'b1;
        tick();
        chk("t1_access_psel",    64'(bus_if.apbm_psel_o), 64'd1);
        chk("t1_access_penable", 64'(bus_if.apbm_penable_o), 64'd1);
        chk("t1_access_pwdata",  64'(bus_if.apbm_pwdata_o), 64'hDEAD_BEEF);
        bus_if.rsp_ready_i = 1'b1;
        tick();
        bus_if.apbm_pready_i = 1'b0;
        chk("t1_rsp_valid",   64'(bus_if.rsp_valid_o), 64'd1);
        chk("t1_rsp_psel",    64'(bus_if.apbm_psel_o), 64'd0);
        chk("t1_rsp_penable", 64'(bus_if.apbm_penable_o), 64'd0);
        chk("t1_paddr_hold",  64'(bus_if.apbm_paddr_o), 64'h10);
        check_rsp("t1_rsp");
        tick();
        bus_if.rsp_ready_i = 1'b0;
        chk("t1_idle_rsp_valid", 64'(bus_if.rsp_valid_o), 64'd0);
        chk("t1_idle_ready",     64'(bus_if.req_ready_o), 64'd1);

        // 2: read with 5 wait states, APB outputs stable for 6 ACCESS cycles
        exp_q.push_back({1'b0, 1'b0, 32'h1234_5678});
        accept(1'b0, 32'h0000_0020, 32'h0BAD_F00D);
        bus_if.apbm_prdata_i = 32'hAAAA_AAAA;
        tick();
        for (int i = 1; i <= 6; i++) begin
            chk("t2_access_psel",    64'(bus_if.apbm_psel_o), 64'd1);
            chk("t2_access_penable", 64'(bus_if.apbm_penable_o), 64'd1);
            chk("t2_access_paddr",   64'(bus_if.apbm_paddr_o), 64'h20);
            chk("t2_access_pwrite",  64'(bus_if.apbm_pwrite_o), 64'd0);
            chk("t2_access_state",   64'(bus_if.dbg_state_o), 64'(ST_ACCESS));
            if (i == 6) begin
                bus_if.apbm_pready_i = 1'b1;
                bus_if.apbm_prdata_i = 32'h1234_5678;
            end
            tick();
        end
        bus_if.apbm_pready_i = 1'b0;
        bus_if.apbm_prdata_i = 32'hFFFF_FFFF;
        chk("t2_rsp_valid", 64'(bus_if.rsp_valid_o), 64'd1);
        chk("t2_rsp_psel",  64'(bus_if.apbm_psel_o), 64'd0);
        check_rsp("t2_rsp");
        bus_if.rsp_ready_i = 1'b1;
        tick();
        bus_if.rsp_ready_i = 1'b0;
        chk("t2_idle_ready", 64'(bus_if.req_ready_o), 64'd1);

        // 3: write with pslverr, response held while rsp_ready low
        exp_q.push_back({1'b0, 1'b1, 32'h0});
        accept(1'b1, 32'h0000_0030, 32'h0000_55AA);
        bus_if.apbm_pready_i  = 1'b1;
        bus_if.apbm_pslverr_i = 1'b1;
        tick();
        tick();
        bus_if.apbm_pready_i  = 1'b0;
        bus_if.apbm_pslverr_i = 1'b0;
        bus_if.req_valid_i = 1'b1;
        bus_if.req_write_i = 1'b0;
        bus_if.req_addr_i  = 32'h0000_0040;
        for (int i = 0; i < 4; i++) begin
            chk("t3_hold_valid", 64'(bus_if.rsp_valid_o), 64'd1);
            chk("t3_hold_ready", 64'(bus_if.req_ready_o), 64'd0);
            chk("t3_hold_payload",
                64'({bus_if.rsp_timeout_o, bus_if.rsp_err_o, bus_if.rsp_rdata_o}), 64'(exp_q[0]));
            tick();
        end
        bus_if.req_valid_i = 1'b0;
        check_rsp("t3_rsp");
        bus_if.rsp_ready_i = 1'b1;
        tick();
        bus_if.rsp_ready_i = 1'b0;
        chk("t3_idle_ready", 64'(bus_if.req_ready_o), 64'd1);
        chk("t3_no_new_psel", 64'(bus_if.apbm_psel_o), 64'd0);

        // 4: misaligned read, no APB transfer, error response at N+1
        exp_q.push_back({1'b0, 1'b1, 32'h0});
        accept(1'b0, 32'h0000_0013, 32'h0);
        chk("t4_rsp_valid", 64'(bus_if.rsp_valid_o), 64'd1);
        chk("t4_no_psel",   64'(bus_if.apbm_psel_o), 64'd0);
        chk("t4_paddr_hold", 64'(bus_if.apbm_paddr_o), 64'h30);
        check_rsp("t4_rsp");
        bus_if.rsp_ready_i = 1'b1;
        tick();
        bus_if.rsp_ready_i = 1'b0;

`ifdef FCB_APBM_TIMEOUT_EN
        // 5: watchdog abort after TO_CYC ACCESS cycles, then normal traffic
        exp_q.push_back({1'b1, 1'b1, 32'h0});
        bus_if.apbm_prdata_i = 32'hCAFE_0001;
        accept(1'b0, 32'h0000_0044, 32'h0);
        tick();
        for (int i = 0; i < int'(TO_CYC); i++) begin
            chk("t5_access_penable", 64'(bus_if.apbm_penable_o), 64'd1);
            tick();
        end
        chk("t5_abort_psel",  64'(bus_if.apbm_psel_o), 64'd0);
        chk("t5_abort_valid", 64'(bus_if.rsp_valid_o), 64'd1);
        check_rsp("t5_abort_rsp");
        bus_if.rsp_ready_i = 1'b1;
        tick();
        bus_if.rsp_ready_i = 1'b0;
        exp_q.push_back({1'b0, 1'b0, 32'h0});
        run_xfer("t5_write_after", 1'b1, 32'h0000_0048, 32'h0F0F_0F0F, 0, 32'h0, 1'b0);
        exp_q.push_back({1'b0, 1'b0, 32'h5A5A_A5A5});
        run_xfer("t5_pready_at_term", 1'b0, 32'h0000_004C, 32'h0, int'(TO_CYC) - 1, 32'h5A5A_A5A5, 1'b0);
`else
        // 5: without the watchdog a long wait still completes normally
        exp_q.push_back({1'b0, 1'b0, 32'h7777_0000});
        run_xfer("t5_long_wait", 1'b0, 32'h0000_0044, 32'h0, 20, 32'h7777_0000, 1'b0);
`endif

        // 6: reset during ACCESS drops APB strobes immediately
        accept(1'b1, 32'h0000_0050, 32'h1111_2222);
        tick();
        chk("t6_access_penable", 64'(bus_if.apbm_penable_o), 64'd1);
        #2;
        fcb_rst_ni = 1'b0;
        #1;
        chk("t6_rst_psel",      64'(bus_if.apbm_psel_o), 64'd0);
        chk("t6_rst_penable",   64'(bus_if.apbm_penable_o), 64'd0);
        chk("t6_rst_rsp_valid", 64'(bus_if.rsp_valid_o), 64'd0);
        tick();
        fcb_rst_ni = 1'b1;
        tick();
        chk("t6_post_ready",     64'(bus_if.req_ready_o), 64'd1);
        chk("t6_post_rsp_valid", 64'(bus_if.rsp_valid_o), 64'd0);
        chk("t6_post_paddr",     64'(bus_if.apbm_paddr_o), 64'd0);
        exp_q.push_back({1'b0, 1'b0, 32'h8765_4321});
        run_xfer("t6_recover", 1'b0, 32'h0000_0060, 32'h0, 2, 32'h8765_4321, 1'b0);

        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
